// File: rtl/ps2_key_pkg.sv
// Shared definitions for the PS/2 key queue: prefix codes, filter states and the queue entry layout.
package ps2_key_pkg;

    localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BREAK = 8'hF0;

    typedef enum logic {
        F_IDLE,
        F_HELD
    } filter_state_t;

    typedef struct packed {
        logic       flag;
        logic [7:0] code;
    } key_entry_t;

    function automatic logic is_prefix(input logic [7:0] code);
        return (code == PS2_PREFIX_EXT) || (code == PS2_PREFIX_BREAK);
    endfunction

endpackage

// File: rtl/ps2_key_queue_if.sv
// Bundle of controller-side inputs and consumer-side outputs of the key queue.
interface ps2_key_queue_if #(
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [7:0]    PS2_code;
    logic          PS2_code_ready;
    logic          PS2_make_code;
    logic          Case_flag;
    logic          Clear;
    logic          Pop;
    logic [7:0]    Key_code;
    logic          Key_flag;
    logic          Key_valid;
    logic [CW-1:0] Count;
    logic          Overflow;

    modport master (
        output PS2_code, PS2_code_ready, PS2_make_code, Case_flag, Clear, Pop,
        input  Key_code, Key_flag, Key_valid, Count, Overflow
    );

    modport slave (
        input  PS2_code, PS2_code_ready, PS2_make_code, Case_flag, Clear, Pop,
        output Key_code, Key_flag, Key_valid, Count, Overflow
    );

endinterface

// File: rtl/key_fifo.sv
// First-word-fall-through queue of key entries; the head register holds its last value when empty.
module key_fifo
    import ps2_key_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  key_entry_t             din,
    output key_entry_t             head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE        = (AW+1)'(1);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    key_entry_t    mem [DEPTH];
    key_entry_t    head_q;
    key_entry_t    head_next;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count_q;
    logic          do_pop;
    logic          do_push;

    assign full    = (count_q == FULL_COUNT);
    assign empty   = (count_q == '0);
    assign do_pop  = pop & ~empty & ~clear;
    assign do_push = push & (~full | do_pop) & ~clear;
    assign head    = head_q;
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Head is pre-computed so it already shows the post-edge entry; with one entry
    // and push+pop together the next entry is the one being written, not yet in mem.
    always_comb begin
        head_next = head_q;
        if (do_pop) begin
            if (count_q > ONE) head_next = mem[rd_ptr + 1'b1];
            else if (do_push)  head_next = din;
        end else if (do_push && empty) begin
            head_next = din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            head_q  <= '0;
        end else if (clear) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            head_q <= head_next;
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_queue.sv
// PS/2 scan-code queue: edge-detects codes, filters prefixes and typematic repeats, buffers key presses.
module ps2_key_queue
    import ps2_key_pkg::*;
#(
    parameter int DEPTH         = 16,
    parameter int REPEAT_FILTER = 1
) (
    input logic            Clock_50,
    input logic            Resetn,
    ps2_key_queue_if.slave bus
);
    filter_state_t          state;
    logic [7:0]             held_code;
    logic                   ready_q;
    logic                   armed;
    logic                   overflow_q;
    logic                   code_event;
    logic                   accepted;
    logic                   make_ev;
    logic                   break_ev;
    logic                   repeat_hit;
    logic                   push_req;
    logic                   pop_ok;
    key_entry_t             entry_in;
    key_entry_t             head;
    logic [$clog2(DEPTH):0] count;
    logic                   full;
    logic                   empty;

    // armed stays low for the first edge after reset so a level already high is not an event
    assign code_event = bus.PS2_code_ready & ~ready_q & armed;
    assign accepted   = code_event & ~is_prefix(bus.PS2_code);
    assign make_ev    = accepted & bus.PS2_make_code;
    assign break_ev   = accepted & ~bus.PS2_make_code;
    assign repeat_hit = (state == F_HELD) && (bus.PS2_code == held_code);
    assign push_req   = make_ev & ~(repeat_hit && (REPEAT_FILTER != 0));
    assign pop_ok     = bus.Pop & ~empty;
    assign entry_in   = '{flag: bus.Case_flag, code: bus.PS2_code};

    key_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (Clock_50),
        .rst_n(Resetn),
        .clear(bus.Clear),
        .push (push_req),
        .pop  (bus.Pop),
        .din  (entry_in),
        .head (head),
        .count(count),
        .full (full),
        .empty(empty)
    );

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            state      <= F_IDLE;
            held_code  <= 8'h00;
            ready_q    <= 1'b0;
            armed      <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            ready_q <= bus.PS2_code_ready;
            armed   <= 1'b1;
            if (bus.Clear) begin
                state      <= F_IDLE;
                overflow_q <= 1'b0;
            end else begin
                if (push_req && full && !pop_ok) overflow_q <= 1'b1;
                if (make_ev) begin
                    state     <= F_HELD;
                    held_code <= bus.PS2_code;
                end else if (break_ev && repeat_hit) begin
                    state <= F_IDLE;
                end
            end
        end
    end

    assign bus.Key_code  = head.code;
    assign bus.Key_flag  = head.flag;
    assign bus.Key_valid = ~empty;
    assign bus.Count     = count;
    assign bus.Overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_key_queue.sv
// Bench for ps2_key_queue: filtered (u_dut) and unfiltered (u_dut_nf) instances share one stimulus.
module tb_ps2_key_queue;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    ps2_key_queue_if #(.DEPTH(16)) bus ();
    ps2_key_queue_if #(.DEPTH(16)) bus_nf ();

    assign bus_nf.PS2_code       = bus.PS2_code;
    assign bus_nf.PS2_code_ready = bus.PS2_code_ready;
    assign bus_nf.PS2_make_code  = bus.PS2_make_code;
    assign bus_nf.Case_flag      = bus.Case_flag;
    assign bus_nf.Clear          = bus.Clear;
    assign bus_nf.Pop            = bus.Pop;

    ps2_key_queue #(.DEPTH(16), .REPEAT_FILTER(1)) u_dut (
        .Clock_50(clk), .Resetn(rst_n), .bus(bus.slave));
    ps2_key_queue #(.DEPTH(16), .REPEAT_FILTER(0)) u_dut_nf (
        .Clock_50(clk), .Resetn(rst_n), .bus(bus_nf.slave));

    typedef struct {
        logic [7:0] code;
        logic       make;
        logic       flag;
        int         exp_count;
        int         exp_count_nf;
    } vec_t;

    int passed = 0;
    int total  = 0;

    logic [8:0] sb [$];
    logic       m_held_v;
    logic [7:0] m_held;
    logic       m_ovf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        sb.delete();
        m_held_v = 1'b0;
        m_held   = 8'h00;
        m_ovf    = 1'b0;
    endtask

    // Filtered-instance reference: decide push from the stimulus, record the expected entry
    task automatic model_event(input logic [7:0] code, input logic make, input logic flag);
        if (code == 8'hE0 || code == 8'hF0) return;
        if (make) begin
            if (!m_held_v || code != m_held) begin
                if (sb.size() < 16) sb.push_back({flag, code});
                else m_ovf = 1'b1;
            end
            m_held_v = 1'b1;
            m_held   = code;
        end else if (m_held_v && code == m_held) begin
            m_held_v = 1'b0;
        end
    endtask

    // Drives one code event; the caller checks right after the first edge (event + 1)
    task automatic send_start(input logic [7:0] code, input logic make, input logic flag);
        bus.PS2_code       = code;
        bus.PS2_make_code  = make;
        bus.Case_flag      = flag;
        bus.PS2_code_ready = 1'b1;
        model_event(code, make, flag);
        tick();
    endtask

    task automatic send_end();
        bus.PS2_code_ready = 1'b0;
        tick();
    endtask

    task automatic send(input logic [7:0] code, input logic make, input logic flag);
        send_start(code, make, flag);
        send_end();
    endtask

    task automatic pop_check(input string name);
        check({name, "_valid"}, 32'(bus.Key_valid), 32'd1);
        if (sb.size() == 0) begin
            check({name, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            check({name, "_head"}, {23'd0, bus.Key_flag, bus.Key_code}, {23'd0, sb[0]});
            void'(sb.pop_front());
        end
        bus.Pop = 1'b1;
        tick();
        bus.Pop = 1'b0;
    endtask

    task automatic do_clear();
        bus.Clear = 1'b1;
        tick();
        bus.Clear = 1'b0;
        model_clear();
    endtask

    initial begin
        vec_t vecs[10];
        vecs[0] = '{8'h1C, 1'b1, 1'b0, 1, 1};
        vecs[1] = '{8'hF0, 1'b0, 1'b0, 1, 1};
        vecs[2] = '{8'h1C, 1'b0, 1'b0, 1, 1};
        vecs[3] = '{8'h32, 1'b1, 1'b0, 2, 2};
        vecs[4] = '{8'h32, 1'b1, 1'b0, 2, 3};
        vecs[5] = '{8'h32, 1'b1, 1'b0, 2, 4};
        vecs[6] = '{8'hE0, 1'b1, 1'b0, 2, 4};
        vecs[7] = '{8'h15, 1'b1, 1'b1, 3, 5};
        vecs[8] = '{8'h99, 1'b0, 1'b0, 3, 5};
        vecs[9] = '{8'h15, 1'b1, 1'b0, 3, 6};

        bus.PS2_code = 8'h00; bus.PS2_code_ready = 1'b0; bus.PS2_make_code = 1'b0;
        bus.Case_flag = 1'b0; bus.Clear = 1'b0; bus.Pop = 1'b0;
        model_clear();
        rst_n = 1'b0;
        tick(); tick();
        check("rst_count", 32'(bus.Count), 32'd0);
        check("rst_valid", 32'(bus.Key_valid), 32'd0);
        check("rst_code", 32'(bus.Key_code), 32'd0);
        check("rst_flag", 32'(bus.Key_flag), 32'd0);
        check("rst_ovf", 32'(bus.Overflow), 32'd0);
        rst_n = 1'b1;
        tick();

        // Table: make/break/prefix/repeat sequences, counts checked one cycle after each event
        for (int i = 0; i < 10; i++) begin
            send_start(vecs[i].code, vecs[i].make, vecs[i].flag);
            check($sformatf("vec%0d_count", i), 32'(bus.Count), 32'(vecs[i].exp_count));
            check($sformatf("vec%0d_count_nf", i), 32'(bus_nf.Count), 32'(vecs[i].exp_count_nf));
            if (i == 0) check("vec0_valid", 32'(bus.Key_valid), 32'd1);
            send_end();
        end
        for (int i = 0; i < 3; i++) pop_check($sformatf("tbl_pop%0d", i));
        check("tbl_empty", 32'(bus.Key_valid), 32'd0);
        do_clear();
        check("clr_count_nf", 32'(bus_nf.Count), 32'd0);

        // Typematic repeat then release
        for (int i = 0; i < 3; i++) send(8'h1C, 1'b1, 1'b0);
        send(8'h1C, 1'b0, 1'b0);
        check("rep_count", 32'(bus.Count), 32'd1);
        check("rep_count_nf", 32'(bus_nf.Count), 32'd3);
        do_clear();

        // Overflow: 17 distinct makes, no pops
        for (int i = 0; i < 16; i++) send(8'(8'h20 + i), 1'b1, 1'b0);
        check("fill_count", 32'(bus.Count), 32'd16);
        check("fill_ovf", 32'(bus.Overflow), 32'd0);
        send(8'h30, 1'b1, 1'b0);
        check("ovf_count", 32'(bus.Count), 32'd16);
        check("ovf_flag", 32'(bus.Overflow), 32'(m_ovf));
        check("ovf_head", 32'(bus.Key_code), 32'h20);
        do_clear();
        check("clr_count", 32'(bus.Count), 32'd0);
        check("clr_ovf", 32'(bus.Overflow), 32'd0);
        check("clr_valid", 32'(bus.Key_valid), 32'd0);

        // Full queue: simultaneous push and pop
        for (int i = 0; i < 16; i++) send(8'(8'h40 + i), 1'b1, 1'b0);
        bus.PS2_code = 8'h60; bus.PS2_make_code = 1'b1; bus.Case_flag = 1'b0;
        bus.PS2_code_ready = 1'b1; bus.Pop = 1'b1;
        void'(sb.pop_front());
        model_event(8'h60, 1'b1, 1'b0);
        tick();
        bus.Pop = 1'b0; bus.PS2_code_ready = 1'b0;
        check("pp_full_count", 32'(bus.Count), 32'd16);
        check("pp_full_ovf", 32'(bus.Overflow), 32'd0);
        check("pp_full_head", 32'(bus.Key_code), 32'h41);
        tick();
        for (int i = 0; i < 16; i++) pop_check($sformatf("drain%0d", i));
        bus.Pop = 1'b1;
        tick();
        bus.Pop = 1'b0;
        check("pop_empty_count", 32'(bus.Count), 32'd0);
        check("pop_empty_valid", 32'(bus.Key_valid), 32'd0);
        check("pop_empty_hold", 32'(bus.Key_code), 32'h60);

        // Empty queue: simultaneous push and pop is push only
        bus.PS2_code = 8'h61; bus.PS2_code_ready = 1'b1; bus.Pop = 1'b1;
        model_event(8'h61, 1'b1, 1'b0);
        tick();
        bus.Pop = 1'b0; bus.PS2_code_ready = 1'b0;
        check("pp_empty_count", 32'(bus.Count), 32'd1);
        tick();
        pop_check("pp_empty_pop");
        do_clear();

        // Case flag travels with each entry
        send(8'h15, 1'b1, 1'b1);
        send(8'h1D, 1'b1, 1'b0);
        pop_check("case0");
        pop_check("case1");
        do_clear();

        // Reset mid-operation with ready held high
        for (int i = 0; i < 5; i++) send(8'(8'h50 + i), 1'b1, 1'b0);
        check("pre_rst_count", 32'(bus.Count), 32'd5);
        bus.PS2_code = 8'h70; bus.PS2_make_code = 1'b1; bus.PS2_code_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_count", 32'(bus.Count), 32'd0);
        check("mid_rst_valid", 32'(bus.Key_valid), 32'd0);
        check("mid_rst_code", 32'(bus.Key_code), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        model_clear();
        tick(); tick(); tick();
        check("post_rst_count", 32'(bus.Count), 32'd0);
        check("post_rst_valid", 32'(bus.Key_valid), 32'd0);
        check("post_rst_ovf", 32'(bus.Overflow), 32'd0);
        bus.PS2_code_ready = 1'b0;
        tick();
        send(8'h22, 1'b1, 1'b0);
        check("post_rst_push", 32'(bus.Count), 32'd1);
        pop_check("post_rst_pop");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
